ro_freq_counter: RTL

Measurement end of the latch ring-oscillator entropy/test path.
- Enables an RO via ro_en and samples its asynchronous output ro_in in the system clock domain.
- Counts synchronized rising edges over a programmable gate window and returns the count through a valid/ready result handshake.
- Sits between the RO instances and the QT test controller that reports RO frequency.

---
 rtl/ro_freq_counter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ro_freq_counter.sv
// rtl/ro_freq_counter.sv - gated rising-edge counter for a ring oscillator, with a valid/ready result
// Define RO_FREQ_MINMAX_EN to add min_count/max_count tracking of completed measurements.
module ro_freq_counter #(
  parameter int CNT_W         = 16,
  parameter int GATE_W        = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              ro_in,
  output logic              ro_en,
  output logic              busy,
  output logic [CNT_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
`ifdef RO_FREQ_MINMAX_EN
  input  logic              minmax_clr,
  output logic [CNT_W-1:0]  min_count,
  output logic [CNT_W-1:0]  max_count,
`endif
  output logic              overflow
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

  state_t            state;
  logic              s1, s2, s3;
  logic              rise;
  logic [GATE_W-1:0] gate_q;
  logic [GATE_W-1:0] win_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              sat_hit;
  logic              win_last;

  // Increment is computed combinationally so the final window cycle's edge lands in result.
  always_comb begin
    rise     = s2 & ~s3;
    sat_hit  = rise & (&edge_cnt);
    cnt_next = edge_cnt;
    if (rise && !(&edge_cnt))
      cnt_next = edge_cnt + CNT_W'(1);
    win_last = (win_cnt == gate_q - GATE_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      gate_q       <= '0;
      win_cnt      <= '0;
      settle_cnt   <= '0;
      edge_cnt     <= '0;
      ro_en        <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
`ifdef RO_FREQ_MINMAX_EN
      min_count    <= '1;
      max_count    <= '0;
`endif
    end else begin
      s1 <= ro_in;
      s2 <= s1;
      s3 <= s2;
      case (state)
        IDLE: begin
          if (start) begin
            gate_q <= gate_len;
            busy   <= 1'b1;
            if (gate_len == '0) begin
              result       <= '0;
              overflow     <= 1'b0;
              result_valid <= 1'b1;
              state        <= DONE;
            end else begin
              edge_cnt   <= '0;
              overflow   <= 1'b0;
              settle_cnt <= '0;
              win_cnt    <= '0;
              ro_en      <= 1'b1;
              state      <= ARM;
            end
          end
        end
        ARM: begin
          if (settle_cnt == SETTLE_LAST)
            state <= COUNT;
          else
            settle_cnt <= settle_cnt + SET_W'(1);
        end
        COUNT: begin
          edge_cnt <= cnt_next;
          if (sat_hit)
            overflow <= 1'b1;
          if (win_last) begin
            result       <= cnt_next;
            result_valid <= 1'b1;
            ro_en        <= 1'b0;
            state        <= DONE;
`ifdef RO_FREQ_MINMAX_EN
            if (cnt_next < min_count)
              min_count <= cnt_next;
            if (cnt_next > max_count)
              max_count <= cnt_next;
`endif
          end else begin
            win_cnt <= win_cnt + GATE_W'(1);
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef RO_FREQ_MINMAX_EN
      if (minmax_clr) begin
        min_count <= '1;
        max_count <= '0;
      end
`endif
    end
  end

endmodule
